// File: rtl/common_pkg.sv
// Shared pipeline typedefs: request/response structs of the memory-stage data bus.
package common_pkg;

    typedef struct packed {
        logic        valid;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [7:0]  strobe;
        logic [63:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [63:0] data;
    } dbus_resp_t;

endpackage

// File: rtl/dbus_responder_pkg.sv
// Local types for the data-bus responder: FSM states and counter width.
package dbus_responder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } dbus_state_t;

    localparam int LATENCY_W = 4;

endpackage

// File: rtl/dbus_ram_array.sv
// Purpose: 2^AW x 64 synchronous word RAM with byte enables, read-before-write.
// Latency: rdata valid the cycle after an enabled access.
// Backpressure: none; every enabled cycle performs one access.
module dbus_ram_array #(
    parameter int AW = 12
) (
    input  logic          clk,
    input  logic          en,
    input  logic [AW-1:0] idx,
    input  logic [7:0]    strobe,
    input  logic [63:0]   wdata,
    output logic [63:0]   rdata
);

    logic [63:0] mem [0:(1<<AW)-1];
    logic [63:0] rdata_q;

    // Read returns the word as it was before this cycle's byte writes.
    always_ff @(posedge clk) begin
        if (en) begin
            rdata_q <= mem[idx];
            for (int i = 0; i < 8; i++) begin
                if (strobe[i]) begin
                    mem[idx][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/dbus_responder.sv
// Purpose: slave end of the dbus protocol, one outstanding request served from a byte-strobed RAM.
// Latency: data_ok asserted LATENCY+1 cycles after the accept cycle, for one cycle.
// Backpressure: addr_ok only in IDLE; requester stalls until data_ok.
module dbus_responder
    import common_pkg::*;
    import dbus_responder_pkg::*;
#(
    parameter int AW      = 12,
    parameter int LATENCY = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  dbus_req_t  dreq,
    output dbus_resp_t dresp
);

    dbus_state_t          state_q, state_d;
    logic [LATENCY_W-1:0] cnt_q, cnt_d;
    logic [AW-1:0]        idx_q, idx_d;
    logic [7:0]           strobe_q, strobe_d;
    logic [63:0]          wdata_q, wdata_d;

    logic                 ram_en;
    logic [63:0]          ram_rdata;

    // Size, byte offset and aliased upper address bits never reach the RAM index.
    logic unused_bits;
    assign unused_bits = ^{dreq.size, dreq.addr[31:AW+3], dreq.addr[2:0]};

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        strobe_d = strobe_q;
        wdata_d  = wdata_q;
        ram_en   = 1'b0;

        case (state_q)
            IDLE: begin
                if (dreq.valid) begin
                    idx_d    = dreq.addr[AW+2:3];
                    strobe_d = dreq.strobe;
                    wdata_d  = dreq.data;
                    cnt_d    = LATENCY_W'(LATENCY - 1);
                    state_d  = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    // A reset landing on the access cycle must leave the RAM untouched.
                    ram_en  = !reset;
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        dresp         = '0;
        dresp.addr_ok = (state_q == IDLE) && dreq.valid && !reset;
        dresp.data_ok = (state_q == RESP) && !reset;
        dresp.data    = dresp.data_ok ? ram_rdata : 64'd0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            strobe_q <= '0;
            wdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            strobe_q <= strobe_d;
            wdata_q  <= wdata_d;
        end
    end

    dbus_ram_array #(.AW(AW)) u_ram (
        .clk    (clk),
        .en     (ram_en),
        .idx    (idx_q),
        .strobe (strobe_q),
        .wdata  (wdata_q),
        .rdata  (ram_rdata)
    );

endmodule

// File: tb/tb_dbus_responder.sv
// Randomized scoreboard bench for dbus_responder against a word-array memory model.
module tb_dbus_responder;
    import common_pkg::*;

    localparam int AW = 12;
    localparam int L  = 2;

    logic       clk = 1'b0;
    logic       reset;
    dbus_req_t  dreq;
    dbus_resp_t dresp;

    always #5 clk = ~clk;

    dbus_responder #(.AW(AW), .LATENCY(L)) dut (
        .clk   (clk),
        .reset (reset),
        .dreq  (dreq),
        .dresp (dresp)
    );

    typedef struct {
        logic [63:0] data;
        int          cyc;
        bit          chk;
    } exp_t;

    exp_t        sb[$];
    int          resp_cyc[$];
    logic [63:0] last_data;
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          busy_left = 0;
    logic [63:0] ram_m [0:(1<<AW)-1];
    bit          known [0:(1<<AW)-1];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int midx(input logic [31:0] a);
        return int'((a >> 3) & ((1 << AW) - 1));
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, req);
        end
    endtask

    // Monitor: handshake timing from a cycle count since accept, data from the scoreboard.
    always @(negedge clk) begin
        bit   ea;
        bit   ed;
        exp_t e;
        ea = dreq.valid && !reset && (busy_left == 0);
        ed = !reset && (busy_left == 1);
        check("addr_ok", {63'd0, dresp.addr_ok}, {63'd0, ea});
        check("data_ok", {63'd0, dresp.data_ok}, {63'd0, ed});
        if (dresp.data_ok) begin
            resp_cyc.push_back(cyc);
            last_data = dresp.data;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_resp at cycle %0d: got data_ok=1 expected no response", cyc);
            end else begin
                e = sb.pop_front();
                check("resp_cycle", 64'(e.cyc), 64'(cyc));
                if (e.chk) check("resp_data", dresp.data, e.data);
            end
        end
        if (reset) busy_left = 0;
        else if (ea) busy_left = L + 1;
        else if (busy_left > 0) busy_left--;
    end

    task automatic issue(input logic [31:0] a, input logic [7:0] s, input logic [63:0] d,
                         input bit hold, input bit garble, input bit abort);
        int   t;
        int   i;
        exp_t e;
        dreq.valid  = 1'b1;
        dreq.addr   = a;
        dreq.size   = 3'd3;
        dreq.strobe = s;
        dreq.data   = d;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!dresp.addr_ok && t < 50);
        if (!dresp.addr_ok) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout addr=%h: got no addr_ok expected accept", a);
            dreq.valid = 1'b0;
            return;
        end
        if (!abort) begin
            i      = midx(a);
            e.data = ram_m[i];
            e.chk  = known[i];
            e.cyc  = cyc + L + 1;
            for (int b = 0; b < 8; b++)
                if (s[b]) ram_m[i][8*b +: 8] = d[8*b +: 8];
            if (s == 8'hFF) known[i] = 1'b1;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        if (garble) begin
            repeat (L + 1) begin
                dreq.valid  = 1'($urandom_range(0, 1));
                dreq.addr   = $urandom;
                dreq.strobe = 8'($urandom);
                dreq.data   = {$urandom, $urandom};
                @(posedge clk);
                #1;
            end
            dreq.valid = 1'b0;
        end else if (!hold) begin
            dreq.valid = 1'b0;
        end
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        while (sb.size() != 0 && t < 100) begin
            @(posedge clk);
            t++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL resp_timeout: got %0d pending expected 0", sb.size());
            sb.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        dreq.valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        int          n0;
        int          w;
        logic [31:0] a;
        logic [7:0]  s;
        bit          hold;
        dreq  = '0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        repeat (10) begin
            @(negedge clk);
            check("idle_data", dresp.data, 64'd0);
        end
        @(posedge clk);
        #1;

        issue(32'h80000010, 8'hFF, 64'h1122334455667788, 0, 0, 0);
        wait_done();
        issue(32'h80000010, 8'h00, 64'h0, 0, 0, 0);
        wait_done();
        check("read_full", last_data, 64'h1122334455667788);
        issue(32'h80000013, 8'h08, 64'h00000000AA000000, 0, 0, 0);
        wait_done();
        check("byte_wr_prewrite", last_data, 64'h1122334455667788);
        issue(32'h80000010, 8'h00, 64'h0, 0, 1, 0);
        wait_done();
        check("read_after_byte_wr", last_data, 64'h11223344AA667788);

        issue(32'h80000040, 8'hFF, 64'hA0A1A2A3A4A5A6A7, 1, 0, 0);
        issue(32'h80000048, 8'hFF, 64'hB0B1B2B3B4B5B6B7, 0, 0, 0);
        wait_done();
        n0 = resp_cyc.size();
        issue(32'h80000040, 8'h00, 64'h0, 1, 0, 0);
        issue(32'h80000048, 8'h00, 64'h0, 0, 0, 0);
        wait_done();
        check("b2b_gap", 64'(resp_cyc[n0+1] - resp_cyc[n0]), 64'(L + 2));
        check("b2b_second", last_data, 64'hB0B1B2B3B4B5B6B7);

        issue(32'h80000020, 8'hFF, 64'h0123456789ABCDEF, 0, 0, 0);
        wait_done();
        issue(32'h80000020, 8'hFF, 64'hDEADBEEFCAFEF00D, 0, 0, 1);
        repeat (L - 1) begin
            @(posedge clk);
            #1;
        end
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        idle(2);
        issue(32'h80000020, 8'h00, 64'h0, 0, 0, 0);
        wait_done();
        check("reset_drops_write", last_data, 64'h0123456789ABCDEF);

        issue(32'h80008020, 8'hFF, 64'h5555AAAA33334444, 0, 0, 0);
        wait_done();
        issue(32'h80000020, 8'h00, 64'h0, 0, 0, 0);
        wait_done();
        check("alias_read", last_data, 64'h5555AAAA33334444);

        for (int k = 0; k < 16; k++)
            issue(32'h80001000 + 32'(k * 8), 8'hFF, {$urandom, $urandom}, k != 15, 0, 0);
        wait_done();
        for (int k = 0; k < 300; k++) begin
            w    = $urandom_range(0, 15);
            a    = ($urandom & 32'hFFFF8000) | (32'h00001000 + 32'(w * 8)) | 32'($urandom_range(0, 7));
            s    = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            hold = (k != 299) && ($urandom_range(0, 1) == 1);
            issue(a, s, {$urandom, $urandom}, hold, $urandom_range(0, 3) == 0, 0);
            if (!hold && $urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
        end
        wait_done();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
